// File: rtl/pll_test_pkg.sv
// rtl/pll_test_pkg.sv - default constants and width helper for the pll_test clock-rate demonstrator
package pll_test_pkg;

  localparam int ACC_WIDTH    = 16;
  localparam int FREQ_WORD    = 21845;
  localparam int LED_DIV_BITS = 22;
  localparam int LOCK_CYCLES  = 1024;

  // Number of bits needed to hold values 0 .. n-1 (minimum 1 bit)
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pll_test_nco.sv
// rtl/pll_test_nco.sv - phase-accumulator NCO producing a fractional-rate tick
module pll_test_nco
  import pll_test_pkg::*;
#(
  parameter int ACC_WIDTH = pll_test_pkg::ACC_WIDTH,
  parameter int FREQ_WORD = pll_test_pkg::FREQ_WORD
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable,
  output logic tick
);

  localparam logic [ACC_WIDTH:0] FW_EXT = (ACC_WIDTH+1)'(FREQ_WORD);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH:0]   sum;

  // Accumulate one step; the carry out of the top bit is the tick, seen on the same edge
  always_comb begin
    sum   = {1'b0, acc_q} + FW_EXT;
    acc_d = acc_q;
    tick  = 1'b0;
    if (enable) begin
      acc_d = sum[ACC_WIDTH-1:0];
      tick  = sum[ACC_WIDTH];
    end
  end

  // Phase accumulator register, cleared by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pll_test.sv
// rtl/pll_test.sv - lock delay, NCO-driven divider and LED mapping for the LED bank
module pll_test
  import pll_test_pkg::*;
#(
  parameter int ACC_WIDTH    = pll_test_pkg::ACC_WIDTH,
  parameter int FREQ_WORD    = pll_test_pkg::FREQ_WORD,
  parameter int LED_DIV_BITS = pll_test_pkg::LED_DIV_BITS,
  parameter int LOCK_CYCLES  = pll_test_pkg::LOCK_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5
);

  localparam int CNT_W  = LED_DIV_BITS + 3;
  localparam int LOCK_W = pll_test_pkg::clog2(LOCK_CYCLES + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_d;
  logic              locked_q;
  logic              locked_d;
  logic              tick;

  pll_test_nco #(
    .ACC_WIDTH (ACC_WIDTH),
    .FREQ_WORD (FREQ_WORD)
  ) u_nco (
    .CLK    (CLK),
    .RST    (RST),
    .enable (locked_q),
    .tick   (tick)
  );

  // Count edges until LOCK_CYCLES have elapsed, then hold locked and freeze the counter
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!locked_q) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      if (lock_cnt_d == LOCK_W'(LOCK_CYCLES)) begin
        locked_d = 1'b1;
      end
    end
  end

  // Ripple divider advanced by NCO ticks; wraps freely
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset dominates and restarts the lock sequence
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign LED1 = cnt_q[LED_DIV_BITS-1];
  assign LED2 = cnt_q[LED_DIV_BITS];
  assign LED3 = cnt_q[LED_DIV_BITS+1];
  assign LED4 = cnt_q[LED_DIV_BITS+2];
  assign LED5 = locked_q;

endmodule

// File: tb/tb_pll_test.sv
// tb/tb_pll_test.sv - directed self-checking bench for pll_test
`timescale 1ns/1ps
module tb_pll_test;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #1 clk = ~clk;

  logic a1, a2, a3, a4, a5;
  logic z1, z2, z3, z4, z5;
  logic f1, f2, f3, f4, f5;

  pll_test #(.ACC_WIDTH(4), .FREQ_WORD(8), .LED_DIV_BITS(1), .LOCK_CYCLES(4)) u_a (
    .CLK(clk), .RST(rst), .LED1(a1), .LED2(a2), .LED3(a3), .LED4(a4), .LED5(a5));
  pll_test #(.ACC_WIDTH(4), .FREQ_WORD(0), .LED_DIV_BITS(1), .LOCK_CYCLES(4)) u_z (
    .CLK(clk), .RST(rst), .LED1(z1), .LED2(z2), .LED3(z3), .LED4(z4), .LED5(z5));
  pll_test #(.ACC_WIDTH(4), .FREQ_WORD(15), .LED_DIV_BITS(1), .LOCK_CYCLES(4)) u_f (
    .CLK(clk), .RST(rst), .LED1(f1), .LED2(f2), .LED3(f3), .LED4(f4), .LED5(f5));

  wire [3:0] cnt_a = {a4, a3, a2, a1};
  wire [3:0] cnt_z = {z4, z3, z2, z1};
  wire [3:0] cnt_f = {f4, f3, f2, f1};

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({cnt_a, a5} !== 5'b0) begin
        bad++;
        $display("FAIL reset_a edge %0d: got %b want 00000", i, {cnt_a, a5});
      end
      total++;
      if ({cnt_z, z5, cnt_f, f5} !== 10'b0) begin
        bad++;
        $display("FAIL reset_zf edge %0d: got %b want 0", i, {cnt_z, z5, cnt_f, f5});
      end
    end
  endtask

  task automatic test_lock();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if ({a5, z5, f5} !== ((i == 4) ? 3'b111 : 3'b000)) begin
        bad++;
        $display("FAIL lock edge %0d: got led5 %b want %b", i, {a5, z5, f5}, (i == 4) ? 3'b111 : 3'b000);
      end
      total++;
      if ({cnt_a, cnt_z, cnt_f} !== 12'b0) begin
        bad++;
        $display("FAIL prelock_leds edge %0d: got %h want 000", i, {cnt_a, cnt_z, cnt_f});
      end
    end
  endtask

  task automatic test_free_run();
    logic [3:0] ea, ef;
    for (int k = 1; k <= 32; k++) begin
      step();
      ea = 4'((k / 2) % 16);
      ef = 4'(((15 * k) / 16) % 16);
      total++;
      if (cnt_a !== ea || a5 !== 1'b1) begin
        bad++;
        $display("FAIL run_a k=%0d: got cnt %0d led5 %b want cnt %0d led5 1", k, cnt_a, a5, ea);
      end
      total++;
      if (cnt_f !== ef) begin
        bad++;
        $display("FAIL run_f k=%0d: got cnt %0d want %0d", k, cnt_f, ef);
      end
    end
  endtask

  task automatic test_freq_zero();
    logic [3:0] start_f;
    int zero_bad;
    zero_bad = 0;
    start_f = cnt_f;
    for (int k = 1; k <= 468; k++) begin
      step();
      if (k == 16) begin
        total++;
        if (cnt_f !== 4'(start_f + 4'd15)) begin
          bad++;
          $display("FAIL f15_rate: got cnt %0d want %0d", cnt_f, 4'(start_f + 4'd15));
        end
      end
      if (cnt_z !== 4'd0 || z5 !== 1'b1) zero_bad++;
    end
    total++;
    if (zero_bad !== 0) begin
      bad++;
      $display("FAIL fw0_quiet: got %0d bad cycles want 0", zero_bad);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (cnt_a == 4'd0 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (cnt_a == 4'd0) begin
      bad++;
      $display("FAIL mid_nonzero: got cnt %0d want nonzero", cnt_a);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({cnt_a, a5, cnt_z, z5, cnt_f, f5} !== 15'b0) begin
      bad++;
      $display("FAIL mid_reset_clear: got %b want 0", {cnt_a, a5, cnt_z, z5, cnt_f, f5});
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (a5 !== (i == 4) || cnt_a !== 4'd0) begin
        bad++;
        $display("FAIL relock edge %0d: got led5 %b cnt %0d want led5 %b cnt 0", i, a5, cnt_a, (i == 4));
      end
    end
    step();
    step();
    total++;
    if (cnt_a !== 4'd1) begin
      bad++;
      $display("FAIL relock_tick: got cnt %0d want 1", cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_free_run();
    test_freq_zero();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
